// File: rtl/zx8x_sync_gen.sv
// ZX80/ZX81 line counter, csync, row counter, blanking and NMI/WAIT generation.
// Back-porch blank counter present only when ZX8X_SYNC_BLANK_EN is defined.
module zx8x_sync_gen #(
    parameter int CW       = 8,
    parameter int LINE_LEN = 207,
    parameter int HS_START = 16,
    parameter int HS_END   = 31,
    parameter int ROW_BITS = 3,
    parameter int BP_LEN   = 31
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                ce_cpu_n,
    input  logic                ce_pix,
    input  logic                zx81,
    input  logic                m1_n,
    input  logic                iorq_n,
    input  logic                rd_n,
    input  logic                wr_n,
    input  logic                halt_n,
    input  logic [1:0]          addr_lo,
    output logic                hsync_n,
    output logic                vsync_n,
    output logic                csync_n,
    output logic [ROW_BITS-1:0] row,
    output logic                blank,
    output logic                nmi_n,
    output logic                wait_n
);

    if (!(HS_START <= HS_END && HS_END < LINE_LEN && LINE_LEN <= (1 << CW))) begin : g_bad_cfg
        $fatal(1, "zx8x_sync_gen: need HS_START <= HS_END < LINE_LEN <= 2^CW");
    end

    localparam logic [CW-1:0] LAST  = CW'(LINE_LEN - 1);
    localparam logic [CW-1:0] HS_LO = CW'(HS_START);
    localparam logic [CW-1:0] HS_HI = CW'(HS_END);

    logic [CW-1:0] hcnt;
    logic [CW-1:0] hcnt_nxt;
    logic          hsync_nxt;
    logic          vsync_nxt;
    logic          nmi_en;
    logic          csync_q;
    logic          int_ack;
    logic          kbd_rd;
    logic          io_wr;
    logic          nmi_wr;

    assign int_ack = ~m1_n & ~iorq_n;
    assign kbd_rd  = ~iorq_n & ~rd_n & ~addr_lo[0];
    assign io_wr   = ~iorq_n & ~wr_n;
    assign nmi_wr  = zx81 & io_wr & (addr_lo[0] ^ addr_lo[1]);

    always_comb begin
        hcnt_nxt  = hcnt;
        hsync_nxt = hsync_n;
        vsync_nxt = vsync_n;
        if (ce_cpu_n) begin
            hcnt_nxt  = (int_ack || hcnt == LAST) ? '0 : hcnt + CW'(1);
            hsync_nxt = ~(hcnt_nxt >= HS_LO && hcnt_nxt <= HS_HI);
        end
        // While ZX81 NMIs are running, the CPU's port traffic must not touch vsync.
        if (!zx81 || !nmi_en) begin
            if (kbd_rd) begin
                vsync_nxt = 1'b0;
            end else if (io_wr) begin
                vsync_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hcnt    <= '0;
            hsync_n <= 1'b1;
            vsync_n <= 1'b1;
            nmi_en  <= 1'b0;
            csync_q <= 1'b1;
            row     <= '0;
        end else begin
            hcnt    <= hcnt_nxt;
            hsync_n <= hsync_nxt;
            vsync_n <= vsync_nxt;
            csync_q <= csync_n;
            if (nmi_wr) begin
                nmi_en <= addr_lo[1];
            end
            if (!vsync_n) begin
                row <= '0;
            end else if (csync_q && !csync_n) begin
                row <= row + ROW_BITS'(1);
            end
        end
    end

    assign csync_n = hsync_n & vsync_n;
    assign nmi_n   = ~(zx81 & nmi_en & ~hsync_n);
    assign wait_n  = ~(zx81 & halt_n & ~nmi_n);

`ifdef ZX8X_SYNC_BLANK_EN
    localparam int BPW = (BP_LEN < 1) ? 1 : $clog2(BP_LEN + 1);
    localparam logic [BPW-1:0] BP_TOP = BPW'(BP_LEN);

    logic [BPW-1:0] bp_cnt;
    logic           csync_nxt;

    // Load on the edge where csync rises so blank has no one-cycle gap.
    assign csync_nxt = hsync_nxt & vsync_nxt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            bp_cnt <= '0;
        end else if (!csync_n && csync_nxt) begin
            bp_cnt <= BPW'(1);
        end else if (ce_pix && bp_cnt != '0) begin
            bp_cnt <= (bp_cnt == BP_TOP) ? '0 : bp_cnt + BPW'(1);
        end
    end

    assign blank = ~csync_n | (bp_cnt != '0);
`else
    localparam int unused_bp_len = BP_LEN;
    logic unused_pix;

    assign unused_pix = ce_pix;
    assign blank      = ~csync_n;
`endif

endmodule

// File: tb/tb_zx8x_sync_gen.sv
// Directed bench for zx8x_sync_gen: line timing, NMI/WAIT, ack, vsync, row, blank.
module tb_zx8x_sync_gen;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       ce_cpu_n;
    logic       ce_pix;
    logic       zx81;
    logic       m1_n;
    logic       iorq_n;
    logic       rd_n;
    logic       wr_n;
    logic       halt_n;
    logic [1:0] addr_lo;
    logic       hsync_n;
    logic       vsync_n;
    logic       csync_n;
    logic [2:0] row;
    logic       blank;
    logic       nmi_n;
    logic       wait_n;

    int n_cmp = 0;
    int n_err = 0;
    int exp_h = 0;
    int lows;
    int exp_row;

    zx8x_sync_gen dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ce_cpu_n(ce_cpu_n),
        .ce_pix  (ce_pix),
        .zx81    (zx81),
        .m1_n    (m1_n),
        .iorq_n  (iorq_n),
        .rd_n    (rd_n),
        .wr_n    (wr_n),
        .halt_n  (halt_n),
        .addr_lo (addr_lo),
        .hsync_n (hsync_n),
        .vsync_n (vsync_n),
        .csync_n (csync_n),
        .row     (row),
        .blank   (blank),
        .nmi_n   (nmi_n),
        .wait_n  (wait_n)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_hs();
        return !(exp_h >= 16 && exp_h <= 31);
    endfunction

    // One T-state: a ce_cpu_n clock followed by an idle clock.
    task automatic tstate(input logic ack);
        if (ack) begin
            m1_n   = 1'b0;
            iorq_n = 1'b0;
        end
        ce_cpu_n = 1'b1;
        @(posedge clk_sys);
        #1;
        ce_cpu_n = 1'b0;
        m1_n     = 1'b1;
        iorq_n   = 1'b1;
        exp_h    = (ack || exp_h == 206) ? 0 : exp_h + 1;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic run_to(input int target);
        tstate(1'b0);
        while (exp_h != target) tstate(1'b0);
    endtask

    task automatic io_cycle(input logic rd, input logic [1:0] a);
        iorq_n  = 1'b0;
        rd_n    = ~rd;
        wr_n    = rd;
        addr_lo = a;
        @(posedge clk_sys);
        #1;
        iorq_n  = 1'b1;
        rd_n    = 1'b1;
        wr_n    = 1'b1;
        addr_lo = 2'b00;
    endtask

    task automatic pix_tick();
        ce_pix = 1'b1;
        @(posedge clk_sys);
        #1;
        ce_pix = 1'b0;
    endtask

    task automatic check_reset_outs(input logic exp_wait);
        check("rst_hsync", {7'd0, hsync_n}, 8'd1);
        check("rst_vsync", {7'd0, vsync_n}, 8'd1);
        check("rst_csync", {7'd0, csync_n}, 8'd1);
        check("rst_row", {5'd0, row}, 8'd0);
        check("rst_blank", {7'd0, blank}, 8'd0);
        check("rst_nmi", {7'd0, nmi_n}, 8'd1);
        check("rst_wait", {7'd0, wait_n}, {7'd0, exp_wait});
    endtask

    initial begin
        reset_n  = 1'b0;
        ce_cpu_n = 1'b0;
        ce_pix   = 1'b0;
        zx81     = 1'b1;
        m1_n     = 1'b1;
        iorq_n   = 1'b1;
        rd_n     = 1'b1;
        wr_n     = 1'b1;
        halt_n   = 1'b0;
        addr_lo  = 2'b00;
        repeat (3) @(posedge clk_sys);
        #1;
        check_reset_outs(1'b1);
        reset_n = 1'b1;
        @(posedge clk_sys);
        #1;
        check("idle_hsync", {7'd0, hsync_n}, 8'd1);

        // Free run: window of 16 low ticks, period 207.
        lows = 0;
        for (int i = 0; i < 207; i++) begin
            tstate(1'b0);
            check("run_hsync", {7'd0, hsync_n}, {7'd0, exp_hs()});
            check("run_csync", {7'd0, csync_n}, {7'd0, exp_hs()});
            if (!hsync_n) lows++;
        end
        check("low_ticks", 8'(lows), 8'd16);
        check("nmi_off", {7'd0, nmi_n}, 8'd1);

        // OUT FE enables NMI; with halt_n=0 WAIT stays inactive.
        io_cycle(1'b0, 2'b10);
        for (int i = 0; i < 207; i++) begin
            tstate(1'b0);
            check("nmi_hs", {7'd0, nmi_n}, {7'd0, exp_hs()});
            check("wait_halt0", {7'd0, wait_n}, 8'd1);
        end
        halt_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tstate(1'b0);
            check("wait_halt1", {7'd0, wait_n}, {7'd0, exp_hs()});
        end

        // Acknowledge at hcnt=100 restarts the line.
        run_to(99);
        tstate(1'b1);
        check("ack_h0", {7'd0, hsync_n}, 8'd1);
        for (int i = 0; i < 40; i++) begin
            tstate(1'b0);
            check("ack_hsync", {7'd0, hsync_n}, {7'd0, exp_hs()});
        end

        // Keyboard read ignored while NMIs run.
        io_cycle(1'b1, 2'b10);
        check("kbd_nmi_vs", {7'd0, vsync_n}, 8'd1);

        // Reset mid-hsync.
        run_to(20);
        check("pre_rst_hs", {7'd0, hsync_n}, 8'd0);
        check("pre_rst_nmi", {7'd0, nmi_n}, 8'd0);
        reset_n = 1'b0;
        #1;
        check_reset_outs(1'b1);
        @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        exp_h   = 0;
        for (int i = 0; i < 20; i++) begin
            tstate(1'b0);
            check("post_rst_hs", {7'd0, hsync_n}, {7'd0, exp_hs()});
            check("post_rst_nmi", {7'd0, nmi_n}, 8'd1);
        end

        // ZX80 mode: keyboard IN -> vsync low, row held.
        zx81 = 1'b0;
        run_to(100);
        io_cycle(1'b1, 2'b10);
        check("kbd_vs", {7'd0, vsync_n}, 8'd0);
        check("kbd_csync", {7'd0, csync_n}, 8'd0);
        check("kbd_blank", {7'd0, blank}, 8'd1);
        run_to(20);
        check("vs_row0", {5'd0, row}, 8'd0);
        run_to(100);
        check("vs_row0b", {5'd0, row}, 8'd0);
        io_cycle(1'b0, 2'b11);
        check("out_vs", {7'd0, vsync_n}, 8'd1);

        // Row counts 1..7,0 on successive csync falls.
        exp_row = 0;
        for (int l = 0; l < 8; l++) begin
            run_to(40);
            exp_row = (exp_row + 1) % 8;
            check("row_seq", {5'd0, row}, 8'(exp_row));
        end

        // Back-porch blanking after the csync rise.
        run_to(31);
        check("hs_blank", {7'd0, blank}, 8'd1);
        ce_cpu_n = 1'b1;
        @(posedge clk_sys);
        #1;
        ce_cpu_n = 1'b0;
        exp_h    = 32;
        check("rise_csync", {7'd0, csync_n}, 8'd1);
`ifdef ZX8X_SYNC_BLANK_EN
        check("bp_start", {7'd0, blank}, 8'd1);
        for (int i = 1; i < 31; i++) begin
            pix_tick();
            check("bp_hold", {7'd0, blank}, 8'd1);
        end
        pix_tick();
        check("bp_end", {7'd0, blank}, 8'd0);
`else
        check("nobp_fall", {7'd0, blank}, 8'd0);
        pix_tick();
        check("nobp_pix", {7'd0, blank}, 8'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
